// File: rtl/cs_tx_sched_pkg.sv
// Shared definitions for the TX scheduler: FSM state codes (also exported on
// state_dbg), error-counter width and the select-width helper.
package cs_tx_sched_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'h0,
    ST_SEND = 4'h2,
    ST_DROP = 4'h3,
    ST_DONE = 4'h4,
    ST_GAP  = 4'h5,
    ST_ABRT = 4'h6
  } state_t;

  localparam int ERR_W = 8;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cs_tx_sched_rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// last+1, wrapping modulo NUM_REQ.
module cs_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int SELW    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SELW-1:0]    last,
  output logic               valid,
  output logic [SELW-1:0]    idx
);

  logic [NUM_REQ-1:0] rot;

  function automatic logic [SELW-1:0] wrap_idx(input logic [SELW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NUM_REQ;
    return s[SELW-1:0];
  endfunction

  // rot[k] is the request k+1 positions after the last granted source
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    assign rot[gi] = req[wrap_idx(last, gi + 1)];
  end

  always_comb begin
    valid = |rot;
    idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) idx = wrap_idx(last, k + 1);
    end
  end

endmodule

// File: rtl/cs_tx_sched.sv
// Round-robin scheduler sharing one TX engine among NUM_REQ frame sources,
// with a 4-phase fs/fd handshake, send timeout and inter-frame gap.
module cs_tx_sched
  import cs_tx_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 50000,
  parameter  int GAP_CYC = 8,
  localparam int SELW    = sel_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] fs_req,
  output logic [NUM_REQ-1:0] fd_req,
  input  logic               fifo_full,
  output logic               fs_tx,
  input  logic               fd_tx,
  output logic [SELW-1:0]    tx_sel,
  output logic               err_timeout,
  output logic [ERR_W-1:0]   err_cnt,
  output logic [3:0]         state_dbg
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);

  state_t           state_reg, state_next;
  logic [SELW-1:0]  tx_sel_reg, last_reg;
  logic [TW-1:0]    timer_reg;
  logic [GW-1:0]    gap_reg;
  logic [ERR_W-1:0] err_cnt_reg;
  logic             pick_valid;
  logic [SELW-1:0]  pick_idx;

  cs_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .SELW   (SELW)
  ) u_pick (
    .req  (fs_req),
    .last (last_reg),
    .valid(pick_valid),
    .idx  (pick_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pick_valid && !fifo_full) state_next = ST_SEND;
      // a done arriving on the final timer cycle still completes normally
      ST_SEND: begin
        if (fd_tx)                                 state_next = ST_DROP;
        else if (timer_reg == TW'(TIMEOUT - 1))    state_next = ST_ABRT;
      end
      ST_DROP: if (!fd_tx) state_next = ST_DONE;
      ST_DONE: state_next = ST_GAP;
      ST_ABRT: state_next = ST_GAP;
      ST_GAP:  if (gap_reg == GW'(GAP_CYC - 1)) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    fs_tx       = (state_reg == ST_SEND);
    err_timeout = (state_reg == ST_ABRT);
    fd_req      = '0;
    if (state_reg == ST_DONE) fd_req[tx_sel_reg] = 1'b1;
  end

  // last tracks every grant, aborted ones included, so a hung source rotates out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sel_reg  <= '0;
      last_reg    <= SELW'(NUM_REQ - 1);
      timer_reg   <= '0;
      gap_reg     <= '0;
      err_cnt_reg <= '0;
    end else begin
      if (state_reg == ST_IDLE && state_next == ST_SEND) begin
        tx_sel_reg <= pick_idx;
        last_reg   <= pick_idx;
      end
      timer_reg <= (state_reg == ST_SEND) ? timer_reg + 1'b1 : '0;
      gap_reg   <= (state_reg == ST_GAP)  ? gap_reg + 1'b1   : '0;
      if (state_reg == ST_ABRT && err_cnt_reg != ERR_MAX)
        err_cnt_reg <= err_cnt_reg + 1'b1;
    end
  end

  assign tx_sel    = tx_sel_reg;
  assign err_cnt   = err_cnt_reg;
  assign state_dbg = state_reg;

endmodule

// File: tb/tb_cs_tx_sched.sv
// Bench for cs_tx_sched: directed vector table, mid-transfer reset, random
// transactions and error-counter saturation against a transaction-level model.
module tb_cs_tx_sched;

  localparam int N       = 4;
  localparam int TIMEOUT = 16;
  localparam int GAP_CYC = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [N-1:0] fs_req = '0;
  logic [N-1:0] fd_req;
  logic         fifo_full = 1'b0;
  logic         fs_tx;
  logic         fd_tx = 1'b0;
  logic [1:0]   tx_sel;
  logic         err_timeout;
  logic [7:0]   err_cnt;
  logic [3:0]   state_dbg;

  cs_tx_sched #(
    .NUM_REQ(N),
    .TIMEOUT(TIMEOUT),
    .GAP_CYC(GAP_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fs_req     (fs_req),
    .fd_req     (fd_req),
    .fifo_full  (fifo_full),
    .fs_tx      (fs_tx),
    .fd_tx      (fd_tx),
    .tx_sel     (tx_sel),
    .err_timeout(err_timeout),
    .err_cnt    (err_cnt),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int txn_no = 0;

  // reference model state
  int exp_last = N - 1;
  int exp_err  = 0;
  bit gap_valid = 1'b0;
  int prev_low = 0;

  // observation and engine state
  int         low_run = 0;
  int         last_gap = 0;
  bit         prev_fs = 1'b0;
  int         fd_cnt = 0;
  int         et_cnt = 0;
  logic [N-1:0] last_fdreq = '0;
  int         hi_cnt = 0;
  int         lo_cnt = 0;
  int         eng_delay = 1;
  int         eng_hold = 1;

  typedef struct {
    logic [N-1:0] req;
    int           delay;
    int           hold;
    int           full;
    bit           drop;
    int           exp_sel;
    bit           exp_abort;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rr_model(input logic [N-1:0] req, input int last);
    for (int k = 1; k <= N; k++) begin
      if (req[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // one clock: observe outputs after the edge, then let the engine react
  task automatic step();
    @(posedge clk);
    #1;
    if (fs_tx) begin
      if (!prev_fs) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
    prev_fs = fs_tx;
    if (fd_req != '0) begin
      fd_cnt++;
      last_fdreq = fd_req;
    end
    if (err_timeout) et_cnt++;
    if (fs_tx && !fd_tx) begin
      hi_cnt++;
      if (hi_cnt == eng_delay) fd_tx = 1'b1;
    end else if (!fs_tx) begin
      hi_cnt = 0;
      if (fd_tx) begin
        lo_cnt++;
        if (lo_cnt >= eng_hold) begin
          fd_tx  = 1'b0;
          lo_cnt = 0;
        end
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_fs_tx"}, fs_tx, 0);
    chk({tag, "_fd_req"}, fd_req, 0);
    chk({tag, "_tx_sel"}, tx_sel, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_state"}, state_dbg, 0);
  endtask

  task automatic model_reset();
    exp_last  = N - 1;
    exp_err   = 0;
    gap_valid = 1'b0;
    prev_fs   = 1'b0;
    low_run   = 0;
    fd_tx     = 1'b0;
    hi_cnt    = 0;
    lo_cnt    = 0;
  endtask

  task automatic run_txn(input logic [N-1:0] req, input int delay, input int hold,
                         input int full, input bit drop, output int sel, output bit aborted);
    int exp_sel, exp_hi, n, hi, post;
    bit exp_abort;
    exp_sel   = rr_model(req, exp_last);
    exp_abort = (delay > TIMEOUT);
    exp_hi    = exp_abort ? TIMEOUT : delay;
    sel       = -1;
    aborted   = 1'b0;
    eng_delay = delay;
    eng_hold  = hold;
    fs_req    = req;
    fd_cnt    = 0;
    et_cnt    = 0;
    last_fdreq = '0;
    txn_no++;
    if (full > 0) begin
      fifo_full = 1'b1;
      n = 0;
      repeat (full) begin
        step();
        if (fs_tx) n++;
      end
      chk("full_blocks_grant", n, 0);
      fifo_full = 1'b0;
    end
    n = 0;
    while (!fs_tx && n < 64) begin
      step();
      n++;
    end
    chk("grant_seen", fs_tx, 1);
    if (!fs_tx) return;
    if (full > 0) chk("grant_latency", n, 1);
    if (gap_valid) chk("inter_frame_gap", last_gap, prev_low + ((full > 0) ? full : 1));
    sel = int'(tx_sel);
    chk("tx_sel", tx_sel, exp_sel);
    chk("state_send", state_dbg, 4'h2);
    if (drop) fs_req = '0;
    hi = 1;
    while (fs_tx && hi < TIMEOUT + 10) begin
      step();
      if (fs_tx) hi++;
    end
    chk("fs_tx_high_cycles", hi, exp_hi);
    chk("state_after_send", state_dbg, exp_abort ? 4'h6 : 4'h3);
    chk("tx_sel_hold", tx_sel, exp_sel);
    post = exp_abort ? GAP_CYC : hold + GAP_CYC;
    n = 0;
    repeat (post) begin
      step();
      if (fs_tx) n++;
    end
    chk("fs_tx_low_in_gap", n, 0);
    chk("fd_req_pulses", fd_cnt, exp_abort ? 0 : 1);
    if (!exp_abort) chk("fd_req_vector", last_fdreq, 1 << exp_sel);
    chk("err_timeout_pulses", et_cnt, exp_abort ? 1 : 0);
    if (exp_abort && exp_err < 255) exp_err++;
    chk("err_cnt", err_cnt, exp_err);
    aborted   = (et_cnt != 0);
    exp_last  = exp_sel;
    prev_low  = post + 1;
    gap_valid = 1'b1;
    $display("[TB] txn %0d req=%b delay=%0d hold=%0d full=%0d sel=%0d abort=%0d err_cnt=%0d",
             txn_no, req, delay, hold, full, sel, aborted, err_cnt);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    bit ab;

    vecs[0]  = '{4'b1111,   3, 1,  0, 1'b0, 0, 1'b0};
    vecs[1]  = '{4'b1111,   3, 1,  0, 1'b0, 1, 1'b0};
    vecs[2]  = '{4'b1111,   3, 1,  0, 1'b0, 2, 1'b0};
    vecs[3]  = '{4'b1111,   3, 1,  0, 1'b0, 3, 1'b0};
    vecs[4]  = '{4'b1111,   3, 1,  0, 1'b0, 0, 1'b0};
    vecs[5]  = '{4'b0100,   5, 2,  0, 1'b0, 2, 1'b0};
    vecs[6]  = '{4'b0001,   2, 1, 20, 1'b0, 0, 1'b0};
    vecs[7]  = '{4'b1111, 100, 1,  0, 1'b0, 1, 1'b1};
    vecs[8]  = '{4'b1111,   2, 1,  0, 1'b0, 2, 1'b0};
    vecs[9]  = '{4'b0010,  16, 1,  0, 1'b0, 1, 1'b0};
    vecs[10] = '{4'b1001,   1, 1,  0, 1'b1, 3, 1'b0};
    vecs[11] = '{4'b1001,   1, 3,  0, 1'b0, 0, 1'b0};

    #1 rst = 1'b1;
    #1 chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    for (int i = 0; i < 12; i++) begin
      run_txn(vecs[i].req, vecs[i].delay, vecs[i].hold, vecs[i].full, vecs[i].drop, sel, ab);
      chk("vec_sel", sel, vecs[i].exp_sel);
      chk("vec_abort", ab, vecs[i].exp_abort);
    end
    chk("vec_err_cnt", err_cnt, 1);

    // reset in the middle of a hung transfer
    fs_req = 4'b1111;
    eng_delay = 1000;
    begin
      int n = 0;
      while (!fs_tx && n < 64) begin
        step();
        n++;
      end
    end
    chk("midsend_reached", fs_tx, 1);
    repeat (3) step();
    rst = 1'b1;
    #1 chk_reset("midsend_reset");
    repeat (2) @(posedge clk);
    #1 chk_reset("midsend_hold");
    model_reset();
    rst = 1'b0;
    run_txn(4'b1000, 4, 1, 0, 1'b0, sel, ab);
    chk("after_reset_sel", sel, 3);

    for (int i = 0; i < 40; i++) begin
      run_txn(N'($urandom_range(1, 15)), $urandom_range(1, TIMEOUT + 4),
              $urandom_range(1, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), sel, ab);
    end

    for (int i = 0; i < 256; i++) begin
      run_txn(N'($urandom_range(1, 15)), 1000, 1, 0, 1'b0, sel, ab);
    end
    chk("err_cnt_saturated", err_cnt, 8'hFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
